// File: rtl/acb_ctrl_if.sv
// -----------------------------------------------------------------------------
// acb_ctrl_if
//   Bundles the host request/response handshake and the arithmetic-core
//   command/result signals of acb_ctrl into one interface.
//
//   Parameter:
//     W  operand/result width (GF(2^163) element by default)
//
//   Modports:
//     slave   controller view (acb_ctrl): consumes requests and the core
//             result, and produces responses and core commands.
//     master  environment view (host plus arithmetic core).
//
//   Signals:
//     req_valid/req_ready/req_op/req_a/req_b  host request channel
//     rsp_valid/rsp_ready/rsp_data/rsp_err    host response channel
//     acb_enable/acb_configuration/acb_a/acb_b  commands to the core
//     acb_c/acb_done                          result from the core
// -----------------------------------------------------------------------------
interface acb_ctrl_if #(
   parameter int W = 163
);
   logic         req_valid;
   logic         req_ready;
   logic         req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_err;

   logic         acb_enable;
   logic         acb_configuration;
   logic [W-1:0] acb_a;
   logic [W-1:0] acb_b;
   logic [W-1:0] acb_c;
   logic         acb_done;

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready, acb_c, acb_done,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             acb_enable, acb_configuration, acb_a, acb_b
   );

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready, acb_c, acb_done,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             acb_enable, acb_configuration, acb_a, acb_b
   );
endinterface

// File: rtl/acb_ctrl.sv
// -----------------------------------------------------------------------------
// acb_ctrl
//   Sequencing controller between a host and a GF(2^163) arithmetic core.
//   A request is accepted in IDLE, its operands and mode are latched and held
//   on the core inputs, the core is started with a one-cycle acb_enable pulse,
//   and the controller waits in BUSY for acb_done. The core result is
//   captured and offered to the host until rsp_ready is seen.
//
//   Parameters:
//     W               operand/result width
//     TIMEOUT_CYCLES  maximum BUSY cycles before abort (timeout build only)
//
//   Ports:
//     clk   single clock, all state updates on the rising edge
//     rst   asynchronous, active-low reset
//     bus   acb_ctrl_if.slave (host request/response plus core command/result)
//
//   Optional feature:
//     ACB_CTRL_TIMEOUT_EN  when defined, a BUSY-cycle counter aborts an
//                          operation after TIMEOUT_CYCLES cycles without
//                          acb_done, returning rsp_data=0 with rsp_err=1.
//                          When undefined, rsp_err is tied low and BUSY waits
//                          indefinitely.
// -----------------------------------------------------------------------------
module acb_ctrl #(
   parameter int W              = 163,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   acb_ctrl_if.slave   bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]   state;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         op_q;
   logic [W-1:0] data_q;
   logic         timeout_hit;

`ifdef ACB_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             err_q;

   // Last permitted BUSY cycle without acb_done; acb_done in that same cycle
   // still wins because it is excluded here.
   assign timeout_hit = (state == BUSY) && !bus.acb_done &&
                        (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         // START is always followed by BUSY, so clearing here restarts the
         // count for every operation.
         if (state == START) begin
            to_cnt <= '0;
         end else if ((state == BUSY) && !bus.acb_done) begin
            to_cnt <= to_cnt + CNT_W'(1);
         end

         if (state == BUSY) begin
            if (bus.acb_done) begin
               err_q <= 1'b0;
            end else if (timeout_hit) begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign bus.rsp_err = err_q;
`else
   assign timeout_hit = 1'b0;
   // No abort path exists in this build, so the error flag is constant low.
   assign bus.rsp_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= 1'b0;
         data_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  a_q   <= bus.req_a;
                  b_q   <= bus.req_b;
                  op_q  <= bus.req_op;
                  state <= START;
               end
            end
            START: begin
               state <= BUSY;
            end
            BUSY: begin
               // acb_done is only looked at here; a level left high by the
               // core in any other state has no effect.
               if (bus.acb_done) begin
                  data_q <= bus.acb_c;
                  state  <= RESP;
               end else if (timeout_hit) begin
                  data_q <= '0;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready         = (state == IDLE);
   assign bus.acb_enable        = (state == START);
   assign bus.rsp_valid         = (state == RESP);
   assign bus.rsp_data          = data_q;
   assign bus.acb_a             = a_q;
   assign bus.acb_b             = b_q;
   assign bus.acb_configuration = op_q;

endmodule
